// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier that borrows an external 32-bit ALU for its additions.
// Optional macro EARLY_EXIT_EN: leave RUN as soon as no multiplier bits remain.
module alu_mul_seq #(
  parameter int         ITERS  = 32,
  parameter logic [3:0] OP_ADD = 4'b0010,
  parameter logic [3:0] OP_OR  = 4'b0001,
  parameter logic [3:0] OP_AND = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_out,
  output logic        res_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST_CNT = 6'(ITERS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [5:0]  cnt;
  logic        run_last;

  // State register and datapath: load on accept, one shift-add step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= 32'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      cnt    <= 6'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            acc    <= 32'd0;
            mcand  <= a_in;
            mplier <= b_in;
            cnt    <= 6'd0;
          end else begin
            cnt    <= cnt;
          end
        end
        S_RUN: begin
          if (mplier[0]) begin
            acc <= alu_result;
          end else begin
            acc <= acc;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  // Decide whether the current RUN cycle is the final one
  always_comb begin
    run_last = 1'b0;
`ifdef EARLY_EXIT_EN
    if ((cnt == LAST_CNT) || ((mplier >> 1) == 32'd0)) begin
      run_last = 1'b1;
    end else begin
      run_last = 1'b0;
    end
`else
    if (cnt == LAST_CNT) begin
      run_last = 1'b1;
    end else begin
      run_last = 1'b0;
    end
`endif
  end

  // Next-state and output decode; DONE reuses the ALU (acc | 0) to get the zero flag
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    res_out     = 32'd0;
    res_zero    = 1'b0;
    alu_a       = 32'd0;
    alu_b       = 32'd0;
    alu_op      = OP_AND;
    case (state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        alu_a  = acc;
        alu_b  = mcand;
        alu_op = OP_ADD;
        if (run_last) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        res_out   = acc;
        res_zero  = alu_zero;
        alu_a     = acc;
        alu_b     = 32'd0;
        alu_op    = OP_OR;
        if (res_ready) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
